// File: rtl/jtag_tick_pkg.sv
// Shared command layout, exit codes and LFSR taps for the JTAG tick engine.
package jtag_tick_pkg;

  localparam int CTL_W     = 6;
  localparam int CHAIN_LSB = CTL_W;

  // Low six command bits; chain index sits above them.
  typedef struct packed {
    logic quit;
    logic capture;
    logic trstn;
    logic tdi;
    logic tms;
    logic tck;
  } cmd_ctl_t;

  localparam logic [31:0] EXIT_RUNNING = 32'd0;
  localparam logic [31:0] EXIT_PASS    = 32'd1;
  localparam logic [31:0] EXIT_FAIL    = 32'd2;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/jtag_tick_fifo.sv
// Generic synchronous FIFO, no bypass: a pushed word is visible the next cycle.
// Push is ignored when full, pop is ignored when empty.
module jtag_tick_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jtag_tick_engine.sv
// Replays queued bit-bang commands, one per tick, onto NUM_CHAINS JTAG chains.
// JTAG_TICK_RANDOM_TDO_EN: undriven TDO is filled from a 16-bit LFSR instead of 0.
module jtag_tick_engine
  import jtag_tick_pkg::*;
#(
  parameter int          TICK_DELAY = 50,
  parameter int          NUM_CHAINS = 1,
  parameter int          CMD_DEPTH  = 8,
  parameter int          RSP_DEPTH  = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int         CW         = (NUM_CHAINS <= 1) ? 1 : $clog2(NUM_CHAINS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  init_done,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CW+5:0]         cmd_bits,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_tdo,
  output logic [NUM_CHAINS-1:0] jtag_TCK,
  output logic [NUM_CHAINS-1:0] jtag_TMS,
  output logic [NUM_CHAINS-1:0] jtag_TDI,
  output logic [NUM_CHAINS-1:0] jtag_TRSTn,
  input  logic [NUM_CHAINS-1:0] jtag_TDO_data,
  input  logic [NUM_CHAINS-1:0] jtag_TDO_driven,
  output logic [31:0]           exit
);

  localparam int                CNT_W  = (TICK_DELAY < 1) ? 1 : $clog2(TICK_DELAY + 1);
  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(TICK_DELAY);
  localparam logic [CW:0]       NC_LIM = (CW+1)'(NUM_CHAINS);

  logic [CW+5:0]    head;
  cmd_ctl_t         head_ctl;
  logic [CW-1:0]    head_chain;
  logic             cmd_empty;
  logic             cmd_full;
  logic             rsp_empty;
  logic             rsp_full;
  logic [CNT_W-1:0] cnt;
  logic             sticky;
  logic             r_reset;
  logic             run;
  logic             fire;
  logic             in_range;
  logic             do_cap;
  logic             pin_upd;
  logic             fill;
  logic             tdo_sel;

  assign head_ctl   = cmd_ctl_t'(head[CTL_W-1:0]);
  assign head_chain = head[CHAIN_LSB +: CW];
  assign in_range   = ({1'b0, head_chain} < NC_LIM);

  assign run  = enable && sticky && (exit == EXIT_RUNNING) && !r_reset;
  // A capturing tick waits for response space; the counter parks at 0 meanwhile.
  assign fire = run && (cnt == '0) && !cmd_empty && (!head_ctl.capture || !rsp_full);

  assign do_cap  = fire && head_ctl.capture && in_range;
  assign pin_upd = fire && in_range && !head_ctl.quit;

  assign cmd_ready = !cmd_full;
  assign rsp_valid = !rsp_empty;

`ifdef JTAG_TICK_RANDOM_TDO_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign fill = lfsr[0];
`else
  // Seed only matters when the random fill is built in.
  assign fill = 1'b0 & LFSR_SEED[0];
`endif

  always_comb begin
    tdo_sel = fill;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if (head_chain == CW'(i)) tdo_sel = jtag_TDO_driven[i] ? jtag_TDO_data[i] : fill;
    end
  end

  jtag_tick_fifo #(.WIDTH(CW + 6), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cmd_valid),
    .wdata (cmd_bits),
    .pop   (fire),
    .rdata (head),
    .empty (cmd_empty),
    .full  (cmd_full)
  );

  jtag_tick_fifo #(.WIDTH(1), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clock (clock),
    .reset (reset),
    .push  (do_cap),
    .wdata (tdo_sel),
    .pop   (rsp_ready),
    .rdata (rsp_tdo),
    .empty (rsp_empty),
    .full  (rsp_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_reset <= 1'b1;
      sticky  <= 1'b0;
      cnt     <= RELOAD;
      exit    <= EXIT_RUNNING;
    end else begin
      r_reset <= 1'b0;
      sticky  <= sticky | init_done;
      if (run) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else if (fire) cnt <= RELOAD;
      end
      if (fire && in_range && head_ctl.quit) exit <= head_ctl.tdi ? EXIT_FAIL : EXIT_PASS;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jtag_TCK   <= '0;
      jtag_TMS   <= '1;
      jtag_TDI   <= '0;
      jtag_TRSTn <= '0;
    end else if (pin_upd) begin
      for (int i = 0; i < NUM_CHAINS; i++) begin
        if (head_chain == CW'(i)) begin
          jtag_TCK[i]   <= head_ctl.tck;
          jtag_TMS[i]   <= head_ctl.tms;
          jtag_TDI[i]   <= head_ctl.tdi;
          jtag_TRSTn[i] <= head_ctl.trstn;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tick_engine.sv
// Directed bench for jtag_tick_engine: 5 chains, tick every 5 clocks, 2-entry response queue.
module tb_jtag_tick_engine;

  localparam int NC = 5;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          init_done;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW+5:0] cmd_bits;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_tdo;
  logic [NC-1:0] tck, tms, tdi, trstn, tdo_data, tdo_driven;
  logic [31:0]   exit_code;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;
  logic fill_exp;
  logic [15:0] lfsr_snap;

  always #5 clock = ~clock;

  jtag_tick_engine #(
    .TICK_DELAY (4),
    .NUM_CHAINS (NC),
    .CMD_DEPTH  (4),
    .RSP_DEPTH  (2),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .init_done       (init_done),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_bits        (cmd_bits),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_tdo         (rsp_tdo),
    .jtag_TCK        (tck),
    .jtag_TMS        (tms),
    .jtag_TDI        (tdi),
    .jtag_TRSTn      (trstn),
    .jtag_TDO_data   (tdo_data),
    .jtag_TDO_driven (tdo_driven),
    .exit            (exit_code)
  );

`ifdef JTAG_TICK_RANDOM_TDO_EN
  logic [15:0] m_lfsr;
  always @(posedge clock or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end
`else
  logic [15:0] m_lfsr = 16'h0000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [CW+5:0] mk(input int ch, input logic quit, input logic cap,
                                      input logic rst_n, input logic di, input logic ms,
                                      input logic ck);
    return {CW'(ch), quit, cap, rst_n, di, ms, ck};
  endfunction

  task automatic push(input logic [CW+5:0] c);
    int n;
    n = 0;
    @(negedge clock);
    cmd_bits  = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("push_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts negedges until any pin changes; lfsr_snap holds the fill seen at the tick edge.
  task automatic wait_change(output int cycles);
    logic [4*NC-1:0] start;
    logic            changed;
    start   = {tck, tms, tdi, trstn};
    changed = 1'b0;
    cycles  = 0;
    while (!changed && cycles < 200) begin
      lfsr_snap = m_lfsr;
      @(negedge clock);
      cycles++;
      changed = ({tck, tms, tdi, trstn} != start);
    end
    n_cmp++;
    assert (changed) else begin
      n_err++;
      $error("FAIL tick_timeout: observed no pin change after %0d cycles, required a tick", cycles);
    end
  endtask

  task automatic wait_exit();
    int n;
    n = 0;
    while (exit_code == 32'd0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    n_cmp++;
    assert (exit_code != 32'd0) else begin
      n_err++;
      $error("FAIL exit_timeout: observed exit 0 after %0d cycles, required nonzero", n);
    end
  endtask

  task automatic pop_rsp();
    @(negedge clock) rsp_ready = 1'b1;
    @(negedge clock) rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; init_done = 1'b0; cmd_valid = 1'b0; cmd_bits = '0;
    rsp_ready = 1'b0; tdo_data = '0; tdo_driven = '0;
    repeat (3) @(negedge clock);
    chk("rst_tck", 32'(tck), 32'h00);
    chk("rst_tms", 32'(tms), 32'h1f);
    chk("rst_tdi", 32'(tdi), 32'h00);
    chk("rst_trstn", 32'(trstn), 32'h00);
    chk("rst_exit", exit_code, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);

    // Enabled but init_done never seen: nothing may execute.
    @(negedge clock) begin reset = 1'b0; enable = 1'b1; end
    push(mk(0, 0, 0, 1, 1, 0, 1));
    push(mk(0, 0, 0, 1, 1, 0, 0));
    repeat (100) @(negedge clock);
    chk("idle_trstn", 32'(trstn), 32'h00);
    chk("idle_tms", 32'(tms), 32'h1f);
    chk("idle_tck", 32'(tck), 32'h00);
    chk("idle_exit", exit_code, 32'd0);

    @(negedge clock) init_done = 1'b1;
    @(negedge clock) init_done = 1'b0;
    wait_change(cyc);
    chk("cadence_first", cyc, 32'd5);
    chk("c0_tck", 32'(tck), 32'h01);
    chk("c0_tms", 32'(tms), 32'h1e);
    chk("c0_tdi", 32'(tdi), 32'h01);
    chk("c0_trstn", 32'(trstn), 32'h01);
    wait_change(cyc);
    chk("cadence_second", cyc, 32'd5);
    chk("c1_tck", 32'(tck), 32'h00);

    push(mk(2, 0, 0, 1, 0, 0, 1));
    wait_change(cyc);
    chk("chain2_tms", 32'(tms), 32'h1a);
    chk("chain2_tck", 32'(tck), 32'h04);
    chk("chain2_trstn", 32'(trstn), 32'h05);

    // Chain 5 is out of range and must drain without touching any pin.
    push(mk(5, 0, 0, 1, 0, 0, 1));
    push(mk(1, 0, 0, 1, 0, 0, 1));
    wait_change(cyc);
    chk("after_noop_tms", 32'(tms), 32'h18);
    chk("after_noop_tck", 32'(tck), 32'h06);

    tdo_driven = 5'b00001; tdo_data = 5'b00001; rsp_ready = 1'b0;
    push(mk(0, 0, 1, 1, 0, 0, 0));
    push(mk(0, 0, 1, 1, 0, 0, 0));
    push(mk(0, 0, 1, 1, 1, 1, 1));
    repeat (40) @(negedge clock);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rsp_tdo", 32'(rsp_tdo), 32'd1);
    chk("bp_stalled_tck", 32'(tck), 32'h06);
    chk("bp_stalled_tms", 32'(tms), 32'h18);
    pop_rsp();
    chk("bp_pop_tck", 32'(tck), 32'h06);
    chk("bp_pop_rsp_valid", 32'(rsp_valid), 32'd1);
    @(negedge clock);
    chk("bp_release_tck", 32'(tck), 32'h07);
    chk("bp_release_tms", 32'(tms), 32'h19);
    for (int i = 0; i < 2; i++) begin
      chk("bp_drain_tdo", 32'(rsp_tdo), 32'd1);
      pop_rsp();
    end
    chk("bp_drained", 32'(rsp_valid), 32'd0);

    tdo_driven = 5'b00000; tdo_data = 5'b11111;
    push(mk(0, 0, 1, 1, 1, 1, 0));
    wait_change(cyc);
`ifdef JTAG_TICK_RANDOM_TDO_EN
    fill_exp = lfsr_snap[0];
`else
    fill_exp = 1'b0;
`endif
    tdo_driven = 5'b01000; tdo_data = 5'b01000;
    push(mk(3, 0, 1, 1, 0, 1, 1));
    wait_change(cyc);
    chk("sel_chain3_tck", 32'(tck), 32'h0e);
    chk("undriven_tdo", 32'(rsp_tdo), 32'(fill_exp));
    pop_rsp();
    chk("chain3_driven_tdo", 32'(rsp_tdo), 32'd1);
    tdo_driven = 5'b00000;

    // Quit with tdi=1 leaves pins alone; the following command must never run.
    push(mk(0, 1, 0, 1, 1, 0, 1));
    push(mk(0, 0, 0, 1, 0, 0, 1));
    wait_exit();
    chk("quit_fail_exit", exit_code, 32'd2);
    chk("quit_pins_held", 32'(tck), 32'h0e);
    repeat (30) @(negedge clock);
    chk("post_quit_tck", 32'(tck), 32'h0e);
    chk("post_quit_exit", exit_code, 32'd2);
    push(mk(0, 1, 0, 1, 1, 0, 0));

    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_tck", 32'(tck), 32'h00);
    chk("async_tms", 32'(tms), 32'h1f);
    chk("async_tdi", 32'(tdi), 32'h00);
    chk("async_trstn", 32'(trstn), 32'h00);
    chk("async_exit", exit_code, 32'd0);
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);

    // Stale queued commands would set TCK[0] and then exit 2; a clean queue gives exit 1.
    @(negedge clock) reset = 1'b0;
    @(negedge clock) init_done = 1'b1;
    @(negedge clock) init_done = 1'b0;
    push(mk(0, 1, 0, 1, 0, 0, 0));
    wait_exit();
    chk("quit_pass_exit", exit_code, 32'd1);
    chk("quit_pass_tck", 32'(tck), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
